// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC multiplexed-bus controllers (read and write FSMs).
// Contents:
//   - RTC register addresses and the transfer command byte
//   - number of accesses in one read sequence
//   - controller state encoding
package rtc_pkg;

  // Command slot: writing CMD_TRANSFER to ADDR_CMD copies the RTC counters
  // into its read buffers so the nine reads below see one coherent snapshot.
  localparam logic [7:0] ADDR_CMD      = 8'hF0;
  localparam logic [7:0] CMD_TRANSFER  = 8'hF0;

  localparam logic [7:0] ADDR_SEG      = 8'h21;
  localparam logic [7:0] ADDR_MIN      = 8'h22;
  localparam logic [7:0] ADDR_HORA     = 8'h23;
  localparam logic [7:0] ADDR_DIA      = 8'h24;
  localparam logic [7:0] ADDR_MES      = 8'h25;
  localparam logic [7:0] ADDR_ANIO     = 8'h26;
  localparam logic [7:0] ADDR_SEG_TIM  = 8'h41;
  localparam logic [7:0] ADDR_MIN_TIM  = 8'h42;
  localparam logic [7:0] ADDR_HORA_TIM = 8'h43;

  // One command access followed by nine register reads.
  localparam int N_ACC = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_GAP_AD  = 3'd2,
    ST_DATA    = 3'd3,
    ST_GAP_END = 3'd4,
    ST_FIN     = 3'd5
  } rtc_state_e;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter used to time the address, data and gap phases.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load        - load load_val on the next edge (takes priority over counting)
//   load_val    - phase length minus one
//   tc          - terminal count: counter is at zero (last cycle of the phase)
// The counter stops at zero; it only leaves zero through an explicit load.
module rtc_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload, decrement, or hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/fsm_lec_rtc.sv
// Read-side controller for the RTC multiplexed address/data bus.
// A do_it_lec pulse in IDLE starts one sequence: a transfer command write,
// then nine register reads whose bytes are latched and exposed unchanged.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   do_it_lec           - start request, honoured only in IDLE
//   bus_in              - byte driven by the RTC during read data phases
//   a_d, cs, rd, wr     - bus control (a_d: 0 address / 1 data; others active low)
//   bus_out             - address or command byte driven to the RTC
//   buffer_activo       - 1 while this block owns bus_out
//   busy, done          - sequence in progress / one-cycle completion pulse
//   seg..anio           - latched time/date bytes
//   seg_tim..hora_tim   - latched timer bytes
// All bus outputs are registered: they are decoded from the next state so
// they change on the same edge as the state register, glitch-free.
module fsm_lec_rtc
  import rtc_pkg::*;
#(
  parameter int T_PH  = 4,
  parameter int T_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       do_it_lec,
  input  logic [7:0] bus_in,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] bus_out,
  output logic       buffer_activo,
  output logic       busy,
  output logic       done,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] seg_tim,
  output logic [7:0] min_tim,
  output logic [7:0] hora_tim
);

  localparam int MAXV = (T_PH > T_GAP) ? T_PH : T_GAP;
  localparam int CW   = $clog2(MAXV);
  localparam logic [CW-1:0] PH_LOAD  = CW'(T_PH - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(T_GAP - 1);
  localparam logic [3:0]    IDX_LAST = 4'(N_ACC - 1);

  rtc_state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       tmr_load;
  logic [CW-1:0] tmr_val;
  logic       tmr_tc;
  logic       capture;

  logic       a_d_q, a_d_d, cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       buf_q, buf_d, busy_q, busy_d, done_q, done_d;
  logic [7:0] regs_q [9];
  logic [7:0] regs_d [9];

  // Address for access slot i (slot 0 is the transfer command).
  function automatic logic [7:0] addr_of(input logic [3:0] i);
    case (i)
      4'd0:    addr_of = ADDR_CMD;
      4'd1:    addr_of = ADDR_SEG;
      4'd2:    addr_of = ADDR_MIN;
      4'd3:    addr_of = ADDR_HORA;
      4'd4:    addr_of = ADDR_DIA;
      4'd5:    addr_of = ADDR_MES;
      4'd6:    addr_of = ADDR_ANIO;
      4'd7:    addr_of = ADDR_SEG_TIM;
      4'd8:    addr_of = ADDR_MIN_TIM;
      4'd9:    addr_of = ADDR_HORA_TIM;
      default: addr_of = 8'h00;
    endcase
  endfunction

  rtc_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Next-state, slot index, phase timer reload and read capture.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_val  = PH_LOAD;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (do_it_lec) begin
          state_d  = ST_ADDR;
          idx_d    = 4'd0;
          tmr_load = 1'b1;
          tmr_val  = PH_LOAD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (tmr_tc) begin
          state_d = ST_GAP_AD;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_GAP_AD: begin
        state_d  = ST_DATA;
        tmr_load = 1'b1;
        tmr_val  = PH_LOAD;
      end
      ST_DATA: begin
        if (tmr_tc) begin
          // Last data cycle: the RTC byte is stable, latch it for reads.
          capture  = (idx_q != 4'd0);
          state_d  = ST_GAP_END;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end else begin
          state_d  = ST_DATA;
        end
      end
      ST_GAP_END: begin
        if (tmr_tc) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_FIN;
          end else begin
            state_d  = ST_ADDR;
            idx_d    = idx_q + 4'd1;
            tmr_load = 1'b1;
            tmr_val  = PH_LOAD;
          end
        end else begin
          state_d = ST_GAP_END;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // Bus/status outputs decoded from the state being entered.
  always_comb begin
    a_d_d     = 1'b1;
    cs_d      = 1'b1;
    rd_d      = 1'b1;
    wr_d      = 1'b1;
    bus_out_d = 8'h00;
    buf_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_ADDR: begin
        cs_d      = 1'b0;
        a_d_d     = 1'b0;
        wr_d      = 1'b0;
        buf_d     = 1'b1;
        bus_out_d = addr_of(idx_d);
        busy_d    = 1'b1;
      end
      ST_GAP_AD: begin
        buf_d     = 1'b1;
        bus_out_d = addr_of(idx_d);
        busy_d    = 1'b1;
      end
      ST_DATA: begin
        cs_d   = 1'b0;
        busy_d = 1'b1;
        if (idx_d == 4'd0) begin
          wr_d      = 1'b0;
          buf_d     = 1'b1;
          bus_out_d = CMD_TRANSFER;
        end else begin
          rd_d      = 1'b0;
          buf_d     = 1'b0;
          bus_out_d = addr_of(idx_d);
        end
      end
      ST_GAP_END: begin
        bus_out_d = addr_of(idx_d);
        busy_d    = 1'b1;
      end
      ST_FIN: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Register file: only the slot being read can change, on its capture edge.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      if (capture && (idx_q == 4'(i + 1))) begin
        regs_d[i] = bus_in;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // State, index, output and register-file flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      a_d_q     <= 1'b1;
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      bus_out_q <= 8'h00;
      buf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_d_q     <= a_d_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      bus_out_q <= bus_out_d;
      buf_q     <= buf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      for (int i = 0; i < 9; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign a_d           = a_d_q;
  assign cs            = cs_q;
  assign rd            = rd_q;
  assign wr            = wr_q;
  assign bus_out       = bus_out_q;
  assign buffer_activo = buf_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign seg           = regs_q[0];
  assign min           = regs_q[1];
  assign hora          = regs_q[2];
  assign dia           = regs_q[3];
  assign mes           = regs_q[4];
  assign anio          = regs_q[5];
  assign seg_tim       = regs_q[6];
  assign min_tim       = regs_q[7];
  assign hora_tim      = regs_q[8];

endmodule

// File: tb/tb_fsm_lec_rtc.sv
// Bench for fsm_lec_rtc: one instance at default timing (T_PH=4, T_GAP=2) and
// one at T_PH=2, T_GAP=1, each served by a small RTC model. A cycle-count
// model predicts every output each cycle; directed checks pin timing and data.
module tb_fsm_lec_rtc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, do_it_lec;
  logic [7:0] bus_in0, bus_in1;
  logic [7:0] salt;

  logic       a_d0, cs0, rd0, wr0, ba0, busy0, done0;
  logic [7:0] bo0, seg0, min0, hora0, dia0, mes0, anio0, st0, mt0, ht0;
  logic       a_d1, cs1, rd1, wr1, ba1, busy1, done1;
  logic [7:0] bo1, seg1, min1, hora1, dia1, mes1, anio1, st1, mt1, ht1;

  fsm_lec_rtc dut0 (
    .clk(clk), .reset(reset), .do_it_lec(do_it_lec), .bus_in(bus_in0),
    .a_d(a_d0), .cs(cs0), .rd(rd0), .wr(wr0), .bus_out(bo0),
    .buffer_activo(ba0), .busy(busy0), .done(done0),
    .seg(seg0), .min(min0), .hora(hora0), .dia(dia0), .mes(mes0), .anio(anio0),
    .seg_tim(st0), .min_tim(mt0), .hora_tim(ht0)
  );

  fsm_lec_rtc #(.T_PH(2), .T_GAP(1)) dut1 (
    .clk(clk), .reset(reset), .do_it_lec(do_it_lec), .bus_in(bus_in1),
    .a_d(a_d1), .cs(cs1), .rd(rd1), .wr(wr1), .bus_out(bo1),
    .buffer_activo(ba1), .busy(busy1), .done(done1),
    .seg(seg1), .min(min1), .hora(hora1), .dia(dia1), .mes(mes1), .anio(anio1),
    .seg_tim(st1), .min_tim(mt1), .hora_tim(ht1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic chk_en = 1'b0;

  logic [7:0] addr_tab [10] = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24,
                                8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // RTC register contents, perturbed by salt so successive runs differ.
  function automatic logic [7:0] rtc_val(input logic [7:0] a);
    logic [7:0] v;
    case (a)
      8'h21: v = 8'h59;  8'h22: v = 8'h30;  8'h23: v = 8'h12;
      8'h24: v = 8'h15;  8'h25: v = 8'h04;  8'h26: v = 8'h17;
      8'h41: v = 8'h05;  8'h42: v = 8'h10;  8'h43: v = 8'h01;
      default: v = 8'hEE;
    endcase
    return v ^ salt;
  endfunction

  // RTC models: valid byte only while rd is low, inverted junk otherwise.
  logic [7:0] al0 = 8'h00, al1 = 8'h00;
  always @(negedge clk) begin
    if (!cs0 && !a_d0) al0 <= bo0;
    if (!cs1 && !a_d1) al1 <= bo1;
    bus_in0 <= (!rd0 && !cs0) ? rtc_val(al0) : ~rtc_val(al0);
    bus_in1 <= (!rd1 && !cs1) ? rtc_val(al1) : ~rtc_val(al1);
  end

  // Inputs as seen by the DUTs at each active edge.
  logic       s_rst = 1'b1, s_go = 1'b0;
  logic [7:0] s_bus [2];
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    s_rst    <= reset;
    s_go     <= do_it_lec;
    s_bus[0] <= bus_in0;
    s_bus[1] <= bus_in1;
  end

  // Expected control outputs from the cycle number n within a sequence.
  // Packing: {a_d, cs, rd, wr, buffer_activo, busy, done, bus_out}.
  function automatic logic [14:0] exp_ctl(input int n, input int ph, input int gap);
    int len, k, pos;
    logic a, c, r, w, b, bz, d;
    logic [7:0] bo;
    len = 2*ph + 1 + gap;
    a = 1'b1; c = 1'b1; r = 1'b1; w = 1'b1; b = 1'b0; bz = 1'b0; d = 1'b0; bo = 8'h00;
    if (n == 10*len + 1) begin
      d = 1'b1;
    end else if (n >= 1) begin
      k = (n - 1) / len;
      pos = (n - 1) % len;
      bz = 1'b1;
      if (pos < ph) begin
        a = 1'b0; c = 1'b0; w = 1'b0; b = 1'b1; bo = addr_tab[k];
      end else if (pos == ph) begin
        b = 1'b1; bo = addr_tab[k];
      end else if (pos <= 2*ph) begin
        c = 1'b0;
        if (k == 0) begin w = 1'b0; b = 1'b1; bo = 8'hF0; end
        else r = 1'b0;
      end
    end
    return {a, c, r, w, b, bz, d, bo};
  endfunction

  int         mn  [2] = '{0, 0};
  int         mph [2] = '{4, 2};
  int         mgap[2] = '{2, 1};
  logic [7:0] mreg[2][9];

  // Model step for the edge just passed, then compare both DUTs.
  initial begin
    for (int m = 0; m < 2; m++) for (int i = 0; i < 9; i++) mreg[m][i] = 8'h00;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        int len, k, pos;
        logic [14:0] e, a, msk;
        logic [71:0] er, ar;
        len = 2*mph[m] + 1 + mgap[m];
        if (s_rst) begin
          mn[m] = 0;
          for (int i = 0; i < 9; i++) mreg[m][i] = 8'h00;
        end else if (mn[m] == 0) begin
          if (s_go) mn[m] = 1;
        end else begin
          k = (mn[m] - 1) / len;
          pos = (mn[m] - 1) % len;
          if (mn[m] <= 10*len && k >= 1 && pos == 2*mph[m]) mreg[m][k-1] = s_bus[m];
          if (mn[m] == 10*len + 1) mn[m] = 0;
          else mn[m] = mn[m] + 1;
        end
        e = exp_ctl(mn[m], mph[m], mgap[m]);
        er = '0;
        for (int i = 0; i < 9; i++) er = {er[63:0], mreg[m][i]};
        if (m == 0) begin
          a  = {a_d0, cs0, rd0, wr0, ba0, busy0, done0, bo0};
          ar = {seg0, min0, hora0, dia0, mes0, anio0, st0, mt0, ht0};
        end else begin
          a  = {a_d1, cs1, rd1, wr1, ba1, busy1, done1, bo1};
          ar = {seg1, min1, hora1, dia1, mes1, anio1, st1, mt1, ht1};
        end
        // bus_out only matters while this block drives the bus.
        msk = e[10] ? 15'h7FFF : 15'h7F00;
        if (chk_en) begin
          chk($sformatf("ctl%0d@%0d", m, cyc), a & msk, e & msk);
          chk($sformatf("reg%0d@%0d", m, cyc), ar, er);
        end
      end
    end
  end

  // Bus monitor on the default-timing instance.
  logic mon_clr = 1'b0;
  logic [7:0] addr_q[$];
  int rdlen_q[$];
  int rd_run = 0, wr_dcyc = 0, wr_dbad = 0, ovl = 0, bufrd = 0, done_cnt = 0;
  logic in_addr = 1'b0;
  always @(negedge clk) begin
    if (mon_clr) begin
      addr_q.delete(); rdlen_q.delete();
      rd_run <= 0; wr_dcyc <= 0; wr_dbad <= 0; ovl <= 0; bufrd <= 0; done_cnt <= 0;
      in_addr <= 1'b0;
    end else begin
      in_addr <= (!cs0 && !a_d0);
      if (!cs0 && !a_d0 && !in_addr) addr_q.push_back(bo0);
      if (!rd0) begin
        rd_run <= rd_run + 1;
        if (ba0) bufrd <= bufrd + 1;
      end else begin
        if (rd_run != 0) rdlen_q.push_back(rd_run);
        rd_run <= 0;
      end
      if (!wr0 && a_d0) begin
        wr_dcyc <= wr_dcyc + 1;
        if (bo0 != 8'hF0) wr_dbad <= wr_dbad + 1;
      end
      if (!rd0 && !wr0) ovl <= ovl + 1;
      if (done0) done_cnt <= done_cnt + 1;
    end
  end

  function automatic logic [79:0] addr_vec();
    logic [79:0] v = '0;
    for (int i = 0; i < 10; i++) v = {v[71:0], (i < addr_q.size()) ? addr_q[i] : 8'h00};
    return v;
  endfunction

  // One-cycle start pulse; returns in cycle 1 of the sequence (+2).
  task automatic start_pulse();
    @(posedge clk); #2 do_it_lec = 1'b1; mon_clr = 1'b1;
    @(posedge clk); #2 do_it_lec = 1'b0; mon_clr = 1'b0;
  endtask

  // Cycle numbers (1 = cycle after the sample edge) of done and busy.
  task automatic wait_done(input int limit, output int d0, output int d1,
                           output int bf, output int bl, output int bl1);
    d0 = 0; d1 = 0; bf = 0; bl = 0; bl1 = 0;
    for (int t = 1; t <= limit; t++) begin
      @(negedge clk);
      if (busy0) begin if (bf == 0) bf = t; bl = t; end
      if (busy1) bl1 = t;
      if (done0 && d0 == 0) d0 = t;
      if (done1 && d1 == 0) d1 = t;
      if (d0 != 0 && d1 != 0) break;
    end
  endtask

  initial begin
    int d0, d1, bf, bl, bl1, nb;
    int dn[$];
    reset = 1'b1; do_it_lec = 1'b0; salt = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {a_d0, cs0, rd0, wr0}, 4'hF);
    chk("rst_bus", {bo0, ba0, busy0, done0}, 11'h000);
    chk("rst_regs", {seg0, min0, hora0, dia0, mes0, anio0, st0, mt0, ht0}, 72'h0);
    chk("rst_ctl1", {a_d1, cs1, rd1, wr1, bo1, ba1, busy1, done1}, 15'h7800);
    chk_en = 1'b1;
    @(posedge clk); #2 reset = 1'b0;

    // Full sequence with the reference data set.
    start_pulse();
    wait_done(200, d0, d1, bf, bl, bl1);
    chk("done_cycle", d0, 111);
    chk("done_cycle_fast", d1, 61);
    chk("busy_first", bf, 1);
    chk("busy_last", bl, 110);
    chk("busy_last_fast", bl1, 60);
    repeat (3) @(negedge clk);
    chk("data0", {seg0, min0, hora0, dia0, mes0, anio0, st0, mt0, ht0},
        72'h59_30_12_15_04_17_05_10_01);
    chk("data1", {seg1, min1, hora1, dia1, mes1, anio1, st1, mt1, ht1},
        72'h59_30_12_15_04_17_05_10_01);
    chk("addr_count", addr_q.size(), 10);
    chk("addr_order", addr_vec(), 80'hF0_21_22_23_24_25_26_41_42_43);
    nb = 0;
    foreach (rdlen_q[i]) if (rdlen_q[i] != 4) nb++;
    chk("rd_windows", rdlen_q.size(), 9);
    chk("rd_len", nb, 0);
    chk("wr_data_cycles", wr_dcyc, 4);
    chk("wr_data_byte", wr_dbad, 0);
    chk("rd_wr_overlap", ovl, 0);
    chk("buf_in_rd", bufrd, 0);
    chk("done_pulses", done_cnt, 1);

    // do_it_lec held high: back-to-back runs, one IDLE cycle between them.
    salt = 8'h22;
    @(posedge clk); #2 do_it_lec = 1'b1;
    @(posedge clk); #2;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      if (done0) dn.push_back(t);
      if (t == 112) chk("idle_gap_busy", busy0, 1'b0);
      if (t == 113) chk("restart_busy", busy0, 1'b1);
      if (dn.size() == 2) break;
    end
    @(posedge clk); #2 do_it_lec = 1'b0;
    chk("b2b_count", dn.size(), 2);
    chk("b2b_first", (dn.size() > 0) ? dn[0] : 0, 111);
    chk("b2b_second", (dn.size() > 1) ? dn[1] : 0, 223);
    repeat (70) @(posedge clk);

    // Reset in the middle of a run, on the edge that would start a read window.
    salt = 8'h33;
    start_pulse();
    repeat (59) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("pre_reset_seg", seg0, 8'h6A);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_strobes", {a_d0, cs0, rd0, wr0}, 4'hF);
    chk("mid_rst_status", {ba0, busy0, done0}, 3'b000);
    chk("mid_rst_regs", {seg0, min0, hora0, dia0, mes0, anio0, st0, mt0, ht0}, 72'h0);
    chk("mid_rst_regs1", {seg1, min1, hora1, dia1, mes1, anio1, st1, mt1, ht1}, 72'h0);

    // Fresh start after the reset begins again at the command slot.
    start_pulse();
    wait_done(200, d0, d1, bf, bl, bl1);
    chk("restart_done", d0, 111);
    chk("restart_done_fast", d1, 61);
    chk("restart_addr", addr_vec(), 80'hF0_21_22_23_24_25_26_41_42_43);
    repeat (3) @(negedge clk);
    chk("restart_seg", seg0, 8'h6A);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
